disp_wr_queue: RTL

- Downstream consumer of the text-message writer's `wr_en`/`wr_addr`/`wr_data` stream.
- Buffers display-memory write requests in a small FIFO and commits them to the shared display-RAM write port, one per cycle, only in cycles granted by the memory owner (the scan-out fetch).
- Also provides a hardware clear-screen engine that fills the whole text buffer with one word.
- Sits between content producers (test FSM, future CPU bridge) and the display RAM.

---
 rtl/disp_wr_queue_pkg.sv | 21 ++
 rtl/disp_wr_queue_fifo.sv | 55 +++++
 rtl/disp_wr_queue.sv | 108 ++++++++++
 3 files changed

// File: rtl/disp_wr_queue_pkg.sv
// Shared display types: text-buffer address/word, write-request record and
// the write-queue state encoding.
package video_package;

    typedef logic [11:0] disp_addr_t;
    typedef logic [15:0] disp_data_t;

    typedef struct packed {
        disp_addr_t addr;
        disp_data_t data;
    } disp_wr_req_t;

    typedef enum logic [1:0] {
        WQ_IDLE  = 2'd0,
        WQ_CLEAR = 2'd1
    } wq_state_t;

    localparam int unsigned DISP_TEXT_COLS = 80;
    localparam int unsigned DISP_TEXT_ROWS = 30;

endpackage

// File: rtl/disp_wr_queue_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on data_o while not
// empty, and a pop on a full FIFO frees the slot for a same-cycle push.
module disp_wr_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 28
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    always_comb begin
        empty_o = (count_q == '0);
        full_o  = (count_q == FULL_CNT);
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        data_o  = mem_q[rd_ptr_q];
        level_o = count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/disp_wr_queue.sv
// Display-RAM write queue: buffers producer writes and commits them in granted
// cycles; also runs a hardware clear that fills the whole text buffer.
module disp_wr_queue
    import video_package::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned CLEAR_WORDS = DISP_TEXT_COLS * DISP_TEXT_ROWS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en_i,
    input  disp_addr_t                    wr_addr_i,
    input  disp_data_t                    wr_data_i,
    input  logic                          clear_i,
    input  disp_data_t                    clear_data_i,
    input  logic                          mem_grant_i,
    output logic                          mem_wr_en_o,
    output disp_addr_t                    mem_addr_o,
    output disp_data_t                    mem_data_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overflow_o,
    input  logic                          overflow_clr_i
);
    localparam disp_addr_t CLEAR_LAST = disp_addr_t'(CLEAR_WORDS - 1);

    wq_state_t    state_q;
    disp_addr_t   clr_cnt_q;
    disp_data_t   clr_fill_q;
    logic         mem_wr_en_q;
    disp_addr_t   mem_addr_q;
    disp_data_t   mem_data_q;
    logic         overflow_q;

    disp_wr_req_t head;
    logic         fifo_full, fifo_empty;
    logic         pop, push, drop;

    disp_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(disp_wr_req_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({wr_addr_i, wr_data_i}),
        .data_o  (head),
        .level_o (level_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A clear request wins over draining; a pop frees room for a same-cycle push.
    always_comb begin
        pop  = (state_q == WQ_IDLE) && !clear_i && mem_grant_i && !fifo_empty;
        push = wr_en_i && (!fifo_full || pop);
        drop = wr_en_i && !push;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= WQ_IDLE;
            clr_cnt_q   <= '0;
            clr_fill_q  <= '0;
            mem_wr_en_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            mem_wr_en_q <= 1'b0;
            overflow_q  <= drop | (overflow_q & ~overflow_clr_i);
            case (state_q)
                WQ_IDLE: begin
                    if (clear_i) begin
                        state_q    <= WQ_CLEAR;
                        clr_cnt_q  <= '0;
                        clr_fill_q <= clear_data_i;
                    end else if (pop) begin
                        mem_wr_en_q <= 1'b1;
                        mem_addr_q  <= head.addr;
                        mem_data_q  <= head.data;
                    end
                end
                WQ_CLEAR: begin
                    if (clear_i) begin
                        clr_cnt_q  <= '0;
                        clr_fill_q <= clear_data_i;
                    end else if (mem_grant_i) begin
                        mem_wr_en_q <= 1'b1;
                        mem_addr_q  <= clr_cnt_q;
                        mem_data_q  <= clr_fill_q;
                        if (clr_cnt_q == CLEAR_LAST) state_q <= WQ_IDLE;
                        else clr_cnt_q <= clr_cnt_q + disp_addr_t'(1);
                    end
                end
                default: state_q <= WQ_IDLE;
            endcase
        end
    end

    assign mem_wr_en_o = mem_wr_en_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_data_o  = mem_data_q;
    assign overflow_o  = overflow_q;
    assign busy_o      = (state_q == WQ_CLEAR);

endmodule
